// File: rtl/push_distributor_if.sv
// Handshake bundle between the upstream producer, the push distributor and
// the four downstream FIFOs. The slave side is the distributor itself.
interface push_distributor_if #(
  parameter int DATA_W = 8
) ();

  // Upstream word channel
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic              in_ready;

  // Downstream FIFO side
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [DATA_W-1:0] data_out;

  // Producer / arbiter side: drives words and pops, observes pushes
  modport master (
    output in_valid,
    output in_data,
    output in_dest,
    output pop,
    input  in_ready,
    input  push,
    input  data_out
  );

  // Distributor side
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dest,
    input  pop,
    output in_ready,
    output push,
    output data_out
  );

endinterface

// File: rtl/push_distributor.sv
// Push distributor: takes one word per cycle from upstream into a single
// holding register and forwards it as a one-hot push to one of four FIFOs.
// Occupancy of every FIFO is tracked locally so a word is only pushed when
// its target has room; a word stuck on a full FIFO stalls the whole input
// stream (strict ordering, no bypass).
module push_distributor #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_TH      = 6
) (
  input  logic                clk,
  input  logic                reset_L,
  push_distributor_if.slave   bus,
  output logic [3:0]          almost_full,
  output logic [3:0]          empty,
  output logic [1:0]          state,
  output logic [7:0]          stall_cnt,
  output logic                underflow_err
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] AF_OCC    = OCC_W'(AF_TH);
  localparam logic [OCC_W-1:0] ONE_OCC   = OCC_W'(1);
  localparam logic [OCC_W-1:0] ZERO_OCC  = OCC_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HELD    = 2'b01,
    ST_BLOCKED = 2'b10
  } state_t;

  // Holding register
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        hold_dest;

  // Per-FIFO occupancy
  logic [OCC_W-1:0]  occ [4];

  // Output registers
  logic [3:0]        push_q;
  logic [DATA_W-1:0] data_q;

  // Decoded control
  logic              dispatch;
  logic              in_ready_c;
  logic              accept;
  logic [3:0]        dispatch_vec;
  logic [3:0]        pop_eff;
  logic [3:0]        pop_bad;
  state_t            cur_state;

  // Next occupancy for one FIFO. Callers guarantee inc only when below depth
  // and dec only when non-zero, so the counter can never wrap either way.
  function automatic logic [OCC_W-1:0] occ_next(
    input logic [OCC_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [OCC_W-1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = cur + ONE_OCC;
      2'b01:   nxt = cur - ONE_OCC;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Dispatch / accept decision from the current register contents only
  always_comb begin
    dispatch     = 1'b0;
    dispatch_vec = 4'b0000;
    if (hold_valid && (occ[hold_dest] < DEPTH_OCC)) begin
      dispatch     = 1'b1;
      dispatch_vec = 4'b0001 << hold_dest;
    end else begin
      dispatch     = 1'b0;
      dispatch_vec = 4'b0000;
    end
    in_ready_c = (~hold_valid) | dispatch;
    accept     = bus.in_valid & in_ready_c;
  end

  // Split pop strobes into counted pops and pops against an empty FIFO
  always_comb begin
    pop_eff = 4'b0000;
    pop_bad = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (occ[i] != ZERO_OCC) begin
        pop_eff[i] = bus.pop[i];
        pop_bad[i] = 1'b0;
      end else begin
        pop_eff[i] = 1'b0;
        pop_bad[i] = bus.pop[i];
      end
    end
  end

  // State decode: the state is a pure function of the holding register and
  // the target occupancy, so no separate state flop can disagree with them
  always_comb begin
    cur_state = ST_IDLE;
    if (!hold_valid) begin
      cur_state = ST_IDLE;
    end else if (dispatch) begin
      cur_state = ST_HELD;
    end else begin
      cur_state = ST_BLOCKED;
    end
  end

  // Holding register: load on accept, otherwise drain on dispatch
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      hold_valid <= 1'b0;
      hold_data  <= {DATA_W{1'b0}};
      hold_dest  <= 2'b00;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= bus.in_data;
      hold_dest  <= bus.in_dest;
    end else if (dispatch) begin
      hold_valid <= 1'b0;
    end else begin
      hold_valid <= hold_valid;
    end
  end

  // Registered push strobe and data word; data_out keeps its last value
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      push_q <= 4'b0000;
      data_q <= {DATA_W{1'b0}};
    end else if (dispatch) begin
      push_q <= dispatch_vec;
      data_q <= hold_data;
    end else begin
      push_q <= 4'b0000;
      data_q <= data_q;
    end
  end

  // Occupancy counters: +1 on push, -1 on a legal pop, unchanged on both
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      for (int i = 0; i < 4; i++) begin
        occ[i] <= ZERO_OCC;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        occ[i] <= occ_next(occ[i], dispatch_vec[i], pop_eff[i]);
      end
    end
  end

  // Saturating count of cycles spent with a word waiting on a full FIFO
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      stall_cnt <= 8'd0;
    end else if ((cur_state == ST_BLOCKED) && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Sticky flag for any pop issued against an empty FIFO
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      underflow_err <= 1'b0;
    end else if (pop_bad != 4'b0000) begin
      underflow_err <= 1'b1;
    end else begin
      underflow_err <= underflow_err;
    end
  end

  // Per-FIFO status flags straight from the occupancy registers
  always_comb begin
    almost_full = 4'b0000;
    empty       = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      almost_full[i] = (occ[i] >= AF_OCC);
      empty[i]       = (occ[i] == ZERO_OCC);
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign state        = cur_state;

endmodule

// File: tb/tb_push_distributor.sv
// Self-checking bench for push_distributor. A queue-based reference model
// tracks accepted words and per-FIFO fill levels; directed scenarios check
// against fixed expected values, the random phase against the model.
module tb_push_distributor;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int AF_TH      = 6;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] almost_full;
  logic [3:0] empty;
  logic [1:0] state;
  logic [7:0] stall_cnt;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  push_distributor_if #(.DATA_W(DATA_W)) bus ();

  push_distributor #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .AF_TH(AF_TH)
  ) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus),
    .almost_full(almost_full), .empty(empty), .state(state),
    .stall_cnt(stall_cnt), .underflow_err(underflow_err)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] data; logic [1:0] dest; } word_t;
  word_t      m_q[$];
  int         m_occ[4];
  logic [3:0] m_push;
  logic [7:0] m_data;
  int         m_stall;
  bit         m_uflow;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_occ[i] = 0;
    m_push = 4'b0000; m_data = 8'h00; m_stall = 0; m_uflow = 1'b0;
  endtask

  function automatic bit m_can_go();
    return (m_q.size() != 0) && (m_occ[m_q[0].dest] < FIFO_DEPTH);
  endfunction
  function automatic bit exp_ready();
    return (m_q.size() == 0) || m_can_go();
  endfunction
  function automatic logic [1:0] exp_state();
    if (m_q.size() == 0) return 2'b00;
    return m_can_go() ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [3:0] exp_empty();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_occ[i] == 0);
    return r;
  endfunction
  function automatic logic [3:0] exp_af();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (m_occ[i] >= AF_TH);
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return #1 after it
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] dst, input logic [3:0] p);
    bit go, acc;
    word_t w;
    bus.in_valid = v; bus.in_data = d; bus.in_dest = dst; bus.pop = p;
    go  = m_can_go();
    acc = v && exp_ready();
    @(posedge clk);
    if (m_q.size() != 0 && !go && m_stall < 255) m_stall++;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (m_occ[i] == 0) m_uflow = 1'b1;
        else m_occ[i]--;
      end
    end
    if (go) begin
      w = m_q.pop_front();
      m_push = 4'b0001 << w.dest;
      m_data = w.data;
      m_occ[w.dest]++;
    end else begin
      m_push = 4'b0000;
    end
    if (acc) begin
      w.data = d; w.dest = dst;
      m_q.push_back(w);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 2'b00, 4'b0000);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_L = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_dest = 2'b00; bus.pop = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b expected 1111", empty); end
    checks++; if (almost_full !== 4'b0000) begin errors++; $display("FAIL reset_af: got %b expected 0000", almost_full); end
    checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b expected 0000", bus.push); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.data_out); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_uflow: got %b expected 0", underflow_err); end
    reset_L = 1'b0;
  endtask

  task automatic test_first_word();
    step(1'b1, 8'hA5, 2'd2, 4'b0000);
    checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL first_early_push: got %b expected 0000", bus.push); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_held: got %b expected 01", state); end
    idle();
    checks++; if (bus.push !== 4'b0100) begin errors++; $display("FAIL first_push: got %b expected 0100", bus.push); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL first_data: got %h expected a5", bus.data_out); end
    checks++; if (empty !== 4'b1011) begin errors++; $display("FAIL first_empty: got %b expected 1011", empty); end
    idle();
    checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL first_push_once: got %b expected 0000", bus.push); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL first_data_hold: got %h expected a5", bus.data_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[8];
    step(1'b0, 8'h00, 2'd0, 4'b0100);
    checks++; if (empty !== 4'b1111) begin errors++; $display("FAIL b2b_drain: got %b expected 1111", empty); end
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    for (int k = 0; k <= 8; k++) begin
      step(k < 8, (k < 8) ? words[k] : 8'h00, 2'd0, 4'b0000);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, bus.in_ready); end
      if (k >= 1) begin
        checks++; if (bus.push !== 4'b0001) begin errors++; $display("FAIL b2b_push k=%0d: got %b expected 0001", k, bus.push); end
        checks++; if (bus.data_out !== words[k-1]) begin errors++; $display("FAIL b2b_data k=%0d: got %h expected %h", k, bus.data_out, words[k-1]); end
        checks++; if (almost_full[0] !== (k >= AF_TH)) begin errors++; $display("FAIL b2b_af k=%0d: got %b expected %b", k, almost_full[0], (k >= AF_TH)); end
      end
    end
  endtask

  task automatic test_full_blocking();
    logic [7:0] w9, w10;
    w9 = 8'($urandom); w10 = 8'($urandom);
    step(1'b1, w9, 2'd0, 4'b0000);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL blk_state: got %b expected 10", state); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL blk_ready: got %b expected 0", bus.in_ready); end
    for (int j = 1; j <= 3; j++) begin
      step(1'b1, w10, 2'd1, 4'b0000);
      checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL blk_nopush j=%0d: got %b expected 0000", j, bus.push); end
      checks++; if (stall_cnt !== 8'(j)) begin errors++; $display("FAIL blk_stall j=%0d: got %0d expected %0d", j, stall_cnt, j); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL blk_ready j=%0d: got %b expected 0", j, bus.in_ready); end
    end
    step(1'b1, w10, 2'd1, 4'b0001);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL blk_release: got %b expected 01", state); end
    checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL blk_pop_push: got %b expected 0000", bus.push); end
    checks++; if (stall_cnt !== 8'd4) begin errors++; $display("FAIL blk_stall_final: got %0d expected 4", stall_cnt); end
    step(1'b1, w10, 2'd1, 4'b0000);
    checks++; if (bus.push !== 4'b0001 || bus.data_out !== w9) begin errors++; $display("FAIL blk_w9: got %b/%h expected 0001/%h", bus.push, bus.data_out, w9); end
    idle();
    checks++; if (bus.push !== 4'b0010 || bus.data_out !== w10) begin errors++; $display("FAIL blk_w10: got %b/%h expected 0010/%h", bus.push, bus.data_out, w10); end
    checks++; if (stall_cnt !== 8'd4) begin errors++; $display("FAIL blk_stall_keep: got %0d expected 4", stall_cnt); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] x;
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), 2'd3, 4'b0000);
    idle();
    x = 8'($urandom);
    step(1'b1, x, 2'd3, 4'b0000);
    step(1'b0, 8'h00, 2'd0, 4'b1000);
    checks++; if (bus.push !== 4'b1000 || bus.data_out !== x) begin errors++; $display("FAIL sim_push: got %b/%h expected 1000/%h", bus.push, bus.data_out, x); end
    checks++; if (almost_full[3] !== 1'b0 || empty[3] !== 1'b0) begin errors++; $display("FAIL sim_flags4: got af=%b e=%b expected 0/0", almost_full[3], empty[3]); end
    step(1'b1, 8'($urandom), 2'd3, 4'b0000); idle();
    checks++; if (almost_full[3] !== 1'b0) begin errors++; $display("FAIL sim_af5: got %b expected 0", almost_full[3]); end
    step(1'b1, 8'($urandom), 2'd3, 4'b0000); idle();
    checks++; if (almost_full[3] !== 1'b1) begin errors++; $display("FAIL sim_af6: got %b expected 1", almost_full[3]); end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 2'd0, 4'b0010);
    checks++; if (empty[1] !== 1'b1 || underflow_err !== 1'b0) begin errors++; $display("FAIL uf_legal_pop: got e=%b uf=%b expected 1/0", empty[1], underflow_err); end
    step(1'b0, 8'h00, 2'd0, 4'b0010);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b expected 1", underflow_err); end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL uf_occ0: got %b expected 1", empty[1]); end
    step(1'b1, 8'($urandom), 2'd1, 4'b0000); idle();
    checks++; if (empty[1] !== 1'b0) begin errors++; $display("FAIL uf_refill: got %b expected 0", empty[1]); end
    step(1'b0, 8'h00, 2'd0, 4'b0010);
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL uf_nowrap: got %b expected 1", empty[1]); end
    repeat (3) idle();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 12 && exp_state() != 2'b10; k++) step(1'b1, 8'($urandom), 2'd2, 4'b0000);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL mr_blocked: got %b expected 10", state); end
    for (int k = 0; k < 258; k++) idle();
    checks++; if (stall_cnt !== 8'd255) begin errors++; $display("FAIL mr_stall_sat: got %0d expected 255", stall_cnt); end
    #2;
    reset_L = 1'b1;
    #1;
    checks++; if (state !== 2'b00 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mr_state: got %b/%b expected 00/1", state, bus.in_ready); end
    checks++; if (empty !== 4'b1111 || almost_full !== 4'b0000) begin errors++; $display("FAIL mr_flags: got %b/%b expected 1111/0000", empty, almost_full); end
    checks++; if (bus.push !== 4'b0000 || bus.data_out !== 8'h00) begin errors++; $display("FAIL mr_out: got %b/%h expected 0000/00", bus.push, bus.data_out); end
    checks++; if (stall_cnt !== 8'd0 || underflow_err !== 1'b0) begin errors++; $display("FAIL mr_cnt: got %0d/%b expected 0/0", stall_cnt, underflow_err); end
    model_reset();
    bus.in_valid = 1'b0; bus.pop = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      checks++; if (bus.push !== 4'b0000 || state !== 2'b00) begin errors++; $display("FAIL mr_no_push k=%0d: got %b/%b expected 0000/00", k, bus.push, state); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 4'($urandom & $urandom));
      checks++;
      if (bus.push !== m_push || (m_push != 4'b0000 && bus.data_out !== m_data) ||
          bus.in_ready !== exp_ready() || state !== exp_state() ||
          empty !== exp_empty() || almost_full !== exp_af() ||
          stall_cnt !== 8'(m_stall) || underflow_err !== m_uflow) begin
        errors++;
        $display("FAIL rand n=%0d: got push=%b d=%h rdy=%b st=%b e=%b af=%b sc=%0d uf=%b expected push=%b d=%h rdy=%b st=%b e=%b af=%b sc=%0d uf=%b",
                 n, bus.push, bus.data_out, bus.in_ready, state, empty, almost_full, stall_cnt, underflow_err,
                 m_push, m_data, exp_ready(), exp_state(), exp_empty(), exp_af(), m_stall, m_uflow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_full_blocking();
    test_simultaneous();
    test_underflow();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_distributor.md
PUSH_DISTRIBUTOR -- requirements
Module: push_distributor

Interface
REQ-001 Parameter DATA_W, default 8, width of the data word.
REQ-002 Parameter FIFO_DEPTH, default 8, entries per destination FIFO; occupancy counters are $clog2(FIFO_DEPTH)+1 bits wide (OCC_W, 4 at default).
REQ-003 Parameter AF_TH, default 6, occupancy at or above which almost_full[i] asserts.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, as the following two ports.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_L  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream word available.
REQ-008 in_data  input  DATA_W  upstream word.
REQ-009 in_dest  input  2  destination FIFO index 0..3.
REQ-010 in_ready  output  1  block can accept this cycle (combinational).
REQ-011 pop  input  4  per-FIFO pop strobes from the downstream arbiter.
REQ-012 push  output  4  one-hot push strobes to the four FIFOs (registered).
REQ-013 data_out  output  DATA_W  word written with push (registered).
REQ-014 almost_full  output  4  per-FIFO, occ[i] >= AF_TH (combinational from registers).
REQ-015 empty  output  4  per-FIFO, occ[i] == 0.
REQ-016 state  output  2  FSM state: 00 IDLE, 01 HELD, 10 BLOCKED.
REQ-017 stall_cnt  output  8  saturating count of BLOCKED cycles.
REQ-018 underflow_err  output  1  sticky, pop seen while occ[i] == 0.

Function
REQ-019 Internal state SHALL be: one-entry holding register (hold_valid, hold_data, hold_dest), four occupancy counters occ[0..3], push/data_out registers, stall_cnt, underflow_err.
REQ-020 dispatch SHALL be hold_valid AND occ[hold_dest] < FIFO_DEPTH, evaluated on current register values.
REQ-021 in_ready SHALL be NOT hold_valid OR dispatch; accept = in_valid AND in_ready.
REQ-022 On accept, hold_data/hold_dest SHALL load in_data/in_dest and hold_valid SHALL be 1; otherwise hold_valid clears on dispatch and holds if not.
REQ-023 On dispatch, push SHALL become one-hot of hold_dest and data_out SHALL load hold_data for exactly one cycle; else push = 0 and data_out retains its value.
REQ-024 Latency: word accepted at edge t SHALL appear on push/data_out after edge t+1 if its target is not full; sustained throughput is one word per cycle.
REQ-025 occ[i] SHALL update as occ[i] + (dispatch to i) - (pop[i] AND occ[i] != 0); simultaneous push and pop to the same FIFO leaves occ[i] unchanged.
REQ-026 occ[i] SHALL never exceed FIFO_DEPTH nor wrap below 0.
REQ-027 A pop[i] with occ[i] == 0 SHALL be ignored for counting and SHALL set underflow_err, which stays set until reset.
REQ-028 The FSM SHALL behave as follows:
- IDLE = hold_valid 0.
- HELD = hold_valid 1 and dispatch.
- BLOCKED = hold_valid 1 and not dispatch.
- state is decoded from the registers; no other encodings occur.
REQ-029 A BLOCKED word SHALL leave BLOCKED in the cycle after a pop to its target reduces occ below FIFO_DEPTH.
REQ-030 A BLOCKED word SHALL block acceptance of all following words, including those for non-full FIFOs; there is no reordering.
REQ-031 stall_cnt SHALL increment once per cycle in BLOCKED and saturate at 255.

Reset
REQ-032 While reset_L is high, immediately and without waiting for clk:
- hold_valid = 0, push = 0, data_out = 0, all occ = 0, stall_cnt = 0, underflow_err = 0.
- Consequently state = IDLE, in_ready = 1, empty = 4'b1111, almost_full = 0.
REQ-033 Reset asserted mid-operation SHALL discard any held word, and no push SHALL be issued for it.
REQ-034 The first accept SHALL be possible at the first rising edge after reset_L deasserts.

Verification
REQ-035 Reset check: after reset, in_valid=1, data 0xA5, dest 2 at edge t -> push=4'b0100, data_out=0xA5 after edge t+1; occ[2]=1, empty=4'b1011.
REQ-036 Back-to-back stream: 8 words to dest 0, no pops -> one push per cycle; after the 6th push almost_full[0]=1; after the 8th push occ[0]=8.
REQ-037 Full blocking: 9th word to dest 0, then a word to dest 1 -> state=BLOCKED, in_ready=0, stall_cnt counts, no push to 1; a single pop[0] -> 9th word pushed next cycle, then the dest-1 word.
REQ-038 Simultaneous events: occ[3]=4, push to 3 and pop[3] on the same edge -> occ[3] stays 4.
REQ-039 Underflow: pop[1] with occ[1]=0 -> occ[1] stays 0 and underflow_err=1 until reset.
REQ-040 Mid-operation reset: assert reset_L while in BLOCKED -> all outputs return to REQ-032 values, and no push of the held word occurs after release.
